// File: rtl/acc_stream_arbiter_if.sv
// Stream bundle between the accelerators, the merger and the manager input.
// Upstream side: NUM_ACCS packed AXI-Stream channels. Downstream side: one
// merged channel tagged with the source index on m_tid.
interface acc_stream_arbiter_if #(
  parameter int NUM_ACCS   = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int TID_W = $clog2(NUM_ACCS);

  logic [NUM_ACCS-1:0]            s_tvalid;
  logic [NUM_ACCS-1:0]            s_tready;
  logic [NUM_ACCS*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_ACCS-1:0]            s_tlast;

  logic                           m_tvalid;
  logic                           m_tready;
  logic [TID_W-1:0]               m_tid;
  logic [DATA_WIDTH-1:0]          m_tdata;
  logic                           m_tlast;

  // Merger view: consumes the per-accelerator streams, drives the merged stream.
  modport master (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tid, m_tdata, m_tlast
  );

  // Environment view: accelerators plus the downstream manager.
  modport slave (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tid, m_tdata, m_tlast
  );
endinterface

// File: rtl/acc_stream_arbiter.sv
// Packet-aware N:1 AXI-Stream merger. Round-robin selection between packets,
// grant held until the tlast beat so packets never interleave, one-beat
// registered output carrying the source index on m_tid.
module acc_stream_arbiter #(
  parameter int NUM_ACCS   = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  acc_stream_arbiter_if.master  bus
);
  localparam int TID_W = $clog2(NUM_ACCS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [TID_W-1:0]      rr_ptr_r;
  logic [TID_W-1:0]      rr_ptr_next_s;
  logic [TID_W-1:0]      owner_r;
  logic [TID_W-1:0]      owner_next_s;
  logic [TID_W-1:0]      pick_s;
  logic                  pick_valid_s;
  logic [TID_W-1:0]      sel_s;
  logic                  can_load_s;
  logic                  accept_s;
  logic                  sel_last_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_ACCS-1:0]   ready_s;

  // (base + off) modulo NUM_ACCS; off never exceeds NUM_ACCS so one
  // conditional subtraction suffices, also for non-power-of-two counts.
  function automatic logic [TID_W-1:0] rot_idx(input logic [TID_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_ACCS) begin
      sum = sum - NUM_ACCS;
    end else begin
      sum = sum;
    end
    return TID_W'(sum);
  endfunction

  // Rotating priority scan: walk from the far end back towards rr_ptr so the
  // last hit is the first valid requester at or after rr_ptr.
  always_comb begin
    pick_s       = '0;
    pick_valid_s = 1'b0;
    for (int k = NUM_ACCS - 1; k >= 0; k--) begin
      if (bus.s_tvalid[rot_idx(rr_ptr_r, k)]) begin
        pick_s       = rot_idx(rr_ptr_r, k);
        pick_valid_s = 1'b1;
      end else begin
        pick_s       = pick_s;
      end
    end
  end

  // Grant, upstream ready and selected beat; ready is gated by the output
  // register having room and forced low while reset is asserted.
  always_comb begin
    can_load_s = !bus.m_tvalid || bus.m_tready;
    ready_s    = '0;
    if (state_r == LOCKED) begin
      sel_s = owner_r;
    end else begin
      sel_s = pick_s;
    end
    if (!rst && can_load_s) begin
      if (state_r == LOCKED) begin
        ready_s[owner_r] = 1'b1;
      end else if (pick_valid_s) begin
        ready_s[pick_s] = 1'b1;
      end else begin
        ready_s = '0;
      end
    end else begin
      ready_s = '0;
    end
    accept_s   = |(ready_s & bus.s_tvalid);
    sel_data_s = bus.s_tdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
    sel_last_s = bus.s_tlast[sel_s];
  end

  assign bus.s_tready = ready_s;

  // Next-state logic: a non-final beat locks the grant to its source, the
  // final beat releases it and moves priority past that source.
  always_comb begin
    state_next_s  = state_r;
    rr_ptr_next_s = rr_ptr_r;
    owner_next_s  = owner_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (sel_last_s) begin
            rr_ptr_next_s = rot_idx(pick_s, 1);
          end else begin
            owner_next_s = pick_s;
            state_next_s = LOCKED;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && sel_last_s) begin
          state_next_s  = IDLE;
          rr_ptr_next_s = rot_idx(owner_r, 1);
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      owner_r  <= '0;
    end else begin
      state_r  <= state_next_s;
      rr_ptr_r <= rr_ptr_next_s;
      owner_r  <= owner_next_s;
    end
  end

  // One-beat output buffer: reloads whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tid    <= '0;
      bus.m_tlast  <= 1'b0;
    end else if (can_load_s) begin
      bus.m_tvalid <= accept_s;
      if (accept_s) begin
        bus.m_tdata <= sel_data_s;
        bus.m_tid   <= sel_s;
        bus.m_tlast <= sel_last_s;
      end
    end
  end
endmodule

// File: tb/tb_acc_stream_arbiter.sv
// Self-checking bench for acc_stream_arbiter: directed table, hand-written
// corner sequences, and randomized traffic against a packet-level model.
module tb_acc_stream_arbiter;
  localparam int N  = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_stream_arbiter_if #(.NUM_ACCS(N), .DATA_WIDTH(DW)) bus16 ();
  acc_stream_arbiter_if #(.NUM_ACCS(5), .DATA_WIDTH(DW)) bus5 ();

  acc_stream_arbiter #(.NUM_ACCS(N), .DATA_WIDTH(DW)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.master));
  acc_stream_arbiter #(.NUM_ACCS(5), .DATA_WIDTH(DW)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.master));

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the stream, where priority starts, what the
  // output buffer holds.
  logic        mdl_locked;
  int          mdl_owner;
  int          mdl_ptr;
  logic        mdl_mv;
  logic [63:0] mdl_md;
  int          mdl_mid;
  logic        mdl_ml;
  int          beats_in;
  int          beats_out;

  typedef struct {
    int          src;
    logic        vld;
    logic [63:0] data;
    logic        last;
    logic        mrdy;
    logic [15:0] exp_rdy;
    logic        exp_mv;
    logic [63:0] exp_md;
    logic [3:0]  exp_tid;
    logic        exp_ml;
  } vec_t;

  vec_t tbl[13];
  int   tids[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int src, logic vld, logic [63:0] d, logic l, logic r,
                              logic [15:0] er, logic mv, logic [63:0] md,
                              logic [3:0] t, logic ml);
    vec_t v;
    v.src = src; v.vld = vld; v.data = d; v.last = l; v.mrdy = r;
    v.exp_rdy = er; v.exp_mv = mv; v.exp_md = md; v.exp_tid = t; v.exp_ml = ml;
    return v;
  endfunction

  // Which source the model would offer ready to this cycle.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int i;
    r = '0;
    if (rst || !(!mdl_mv || bus16.m_tready)) return r;
    if (mdl_locked) begin
      r[mdl_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      i = (mdl_ptr + k) % N;
      if (bus16.s_tvalid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    mdl_locked = 1'b0; mdl_owner = 0; mdl_ptr = 0;
    mdl_mv = 1'b0; mdl_md = 64'h0; mdl_mid = 0; mdl_ml = 1'b0;
  endtask

  // One clock: inputs were set at the preceding negedge; check against the
  // model, then advance the model with what crossed at the rising edge.
  task automatic cycle16();
    logic [N-1:0] er;
    logic acc;
    int src;
    #1;
    er = model_ready();
    chk("s_tready", 64'(bus16.s_tready), 64'(er));
    chk("m_tvalid", 64'(bus16.m_tvalid), 64'(mdl_mv));
    if (mdl_mv) begin
      chk("m_tdata", bus16.m_tdata, mdl_md);
      chk("m_tid", 64'(bus16.m_tid), 64'(mdl_mid));
      chk("m_tlast", 64'(bus16.m_tlast), 64'(mdl_ml));
    end
    @(posedge clk);
    if (|(bus16.s_tready & bus16.s_tvalid)) beats_in++;
    if (bus16.m_tvalid && bus16.m_tready) beats_out++;
    if (rst) begin
      model_reset();
    end else begin
      acc = 1'b0;
      src = 0;
      for (int i = 0; i < N; i++) begin
        if (er[i] && bus16.s_tvalid[i]) begin
          acc = 1'b1;
          src = i;
        end
      end
      if (!mdl_mv || bus16.m_tready) begin
        mdl_mv = acc;
        if (acc) begin
          mdl_md  = bus16.s_tdata[src*DW +: DW];
          mdl_mid = src;
          mdl_ml  = bus16.s_tlast[src];
        end
      end
      if (acc) begin
        if (bus16.s_tlast[src]) begin
          mdl_locked = 1'b0;
          mdl_ptr    = (src + 1) % N;
        end else begin
          mdl_locked = 1'b1;
          mdl_owner  = src;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle16();
    bus16.s_tvalid = '0; bus16.s_tlast = '0; bus16.s_tdata = '0; bus16.m_tready = 1'b1;
  endtask

  task automatic do_reset();
    idle16();
    rst = 1'b1;
    cycle16();
    cycle16();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    beats_in = 0; beats_out = 0;
    idle16();
    bus5.s_tvalid = '0; bus5.s_tlast = '0; bus5.s_tdata = '0; bus5.m_tready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state of both instances.
    chk("rst_m_tvalid", 64'(bus16.m_tvalid), 64'h0);
    chk("rst_m_tdata", bus16.m_tdata, 64'h0);
    chk("rst_m_tid", 64'(bus16.m_tid), 64'h0);
    chk("rst5_m_tvalid", 64'(bus5.m_tvalid), 64'h0);

    // Five-source instance: walk priority to 4, then 4 and 0 compete.
    bus5.s_tlast = 5'b11111;
    for (int s = 0; s < 4; s++) begin
      bus5.s_tvalid = 5'(1 << s);
      bus5.s_tdata  = '0;
      bus5.s_tdata[s*DW +: DW] = 64'(s + 100);
      cycle16();
      chk("n5_single_tid", 64'(bus5.m_tid), 64'(s));
      chk("n5_single_data", bus5.m_tdata, 64'(s + 100));
    end
    bus5.s_tvalid = 5'b10001;
    cycle16();
    chk("n5_wrap_first_tid", 64'(bus5.m_tid), 64'd4);
    cycle16();
    chk("n5_wrap_second_tid", 64'(bus5.m_tid), 64'd0);
    chk("n5_wrap_second_vld", 64'(bus5.m_tvalid), 64'd1);
    cycle16();
    chk("n5_wrap_third_tid", 64'(bus5.m_tid), 64'd4);
    bus5.s_tvalid = '0;
    cycle16();

    // Directed table: 3-beat packet from acc 3, then a packet stalled 5 cycles.
    do_reset();
    tbl[0]  = mk(3, 1'b1, 64'hA, 1'b0, 1'b1, 16'h0008, 1'b1, 64'hA, 4'd3, 1'b0);
    tbl[1]  = mk(3, 1'b1, 64'hB, 1'b0, 1'b1, 16'h0008, 1'b1, 64'hB, 4'd3, 1'b0);
    tbl[2]  = mk(3, 1'b1, 64'hC, 1'b1, 1'b1, 16'h0008, 1'b1, 64'hC, 4'd3, 1'b1);
    tbl[3]  = mk(3, 1'b0, 64'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 64'h0, 4'd0, 1'b0);
    tbl[4]  = mk(3, 1'b1, 64'hD, 1'b0, 1'b1, 16'h0008, 1'b1, 64'hD, 4'd3, 1'b0);
    for (int r = 5; r < 10; r++) begin
      tbl[r] = mk(3, 1'b1, 64'hE, 1'b0, 1'b0, 16'h0000, 1'b1, 64'hD, 4'd3, 1'b0);
    end
    tbl[10] = mk(3, 1'b1, 64'hE, 1'b0, 1'b1, 16'h0008, 1'b1, 64'hE, 4'd3, 1'b0);
    tbl[11] = mk(3, 1'b1, 64'hF, 1'b1, 1'b1, 16'h0008, 1'b1, 64'hF, 4'd3, 1'b1);
    tbl[12] = mk(3, 1'b0, 64'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 64'h0, 4'd0, 1'b0);
    beats_in = 0; beats_out = 0;
    for (int r = 0; r < 13; r++) begin
      idle16();
      bus16.s_tvalid[tbl[r].src] = tbl[r].vld;
      bus16.s_tlast[tbl[r].src]  = tbl[r].last;
      bus16.s_tdata[tbl[r].src*DW +: DW] = tbl[r].data;
      bus16.m_tready = tbl[r].mrdy;
      #1;
      chk($sformatf("tbl%0d_s_tready", r), 64'(bus16.s_tready), 64'(tbl[r].exp_rdy));
      cycle16();
      chk($sformatf("tbl%0d_m_tvalid", r), 64'(bus16.m_tvalid), 64'(tbl[r].exp_mv));
      if (tbl[r].exp_mv) begin
        chk($sformatf("tbl%0d_m_tdata", r), bus16.m_tdata, tbl[r].exp_md);
        chk($sformatf("tbl%0d_m_tid", r), 64'(bus16.m_tid), 64'(tbl[r].exp_tid));
        chk($sformatf("tbl%0d_m_tlast", r), 64'(bus16.m_tlast), 64'(tbl[r].exp_ml));
      end
    end
    chk("tbl_beats_in", 64'(beats_in), 64'd6);
    chk("tbl_beats_out", 64'(beats_out), 64'd6);

    // Round robin: every source always offers a single-beat packet.
    do_reset();
    tids.delete();
    for (int c = 0; c < 34; c++) begin
      bus16.s_tvalid = '1;
      bus16.s_tlast  = '1;
      for (int i = 0; i < N; i++) bus16.s_tdata[i*DW +: DW] = {32'(i), 32'(c)};
      cycle16();
      if (bus16.m_tvalid) tids.push_back(int'(bus16.m_tid));
    end
    chk("rr_count", 64'(tids.size()), 64'd34);
    for (int k = 0; k < 32 && k < tids.size(); k++) begin
      chk($sformatf("rr_tid%0d", k), 64'(tids[k]), 64'(k % N));
    end

    // Packet atomicity: acc 1 has a gappy 4-beat packet, acc 0 always valid.
    do_reset();
    tids.delete();
    bus16.s_tvalid[0] = 1'b1; bus16.s_tlast[0] = 1'b1; bus16.s_tdata[0 +: DW] = 64'h55;
    cycle16();
    if (bus16.m_tvalid) tids.push_back(int'(bus16.m_tid));
    for (int c = 0; c < 9; c++) begin
      logic [5:0] vpat;
      int         bidx [6];
      vpat = 6'b101101;
      bidx = '{0, 0, 1, 2, 0, 3};
      bus16.s_tvalid[1] = (c < 6) ? vpat[c] : 1'b0;
      bus16.s_tlast[1]  = (c == 5);
      bus16.s_tdata[DW +: DW] = 64'(16 + ((c < 6) ? bidx[c] : 0));
      cycle16();
      if (bus16.m_tvalid) tids.push_back(int'(bus16.m_tid));
    end
    begin
      int exp_t [8];
      exp_t = '{0, 1, 1, 1, 1, 0, 0, 0};
      chk("atom_count", 64'(tids.size()), 64'd8);
      for (int k = 0; k < 8 && k < tids.size(); k++) begin
        chk($sformatf("atom_tid%0d", k), 64'(tids[k]), 64'(exp_t[k]));
      end
    end

    // Reset in the middle of a packet owned by acc 5.
    do_reset();
    bus16.s_tvalid[5] = 1'b1; bus16.s_tlast[5] = 1'b0; bus16.s_tdata[5*DW +: DW] = 64'h501;
    cycle16();
    bus16.s_tdata[5*DW +: DW] = 64'h502;
    cycle16();
    rst = 1'b1;
    #1;
    chk("midrst_s_tready", 64'(bus16.s_tready), 64'h0);
    cycle16();
    chk("midrst_m_tvalid", 64'(bus16.m_tvalid), 64'h0);
    chk("midrst_s_tready_after", 64'(bus16.s_tready), 64'h0);
    rst = 1'b0;
    idle16();
    bus16.s_tvalid[2] = 1'b1; bus16.s_tvalid[7] = 1'b1;
    bus16.s_tlast[2]  = 1'b1; bus16.s_tlast[7]  = 1'b1;
    bus16.s_tdata[2*DW +: DW] = 64'h22; bus16.s_tdata[7*DW +: DW] = 64'h77;
    cycle16();
    chk("postrst_m_tvalid", 64'(bus16.m_tvalid), 64'h1);
    chk("postrst_m_tid", 64'(bus16.m_tid), 64'd2);

    // Randomized traffic with random backpressure, then drain.
    do_reset();
    beats_in = 0; beats_out = 0;
    for (int c = 0; c < 1500; c++) begin
      bus16.s_tvalid = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        bus16.s_tlast[i] = ($urandom_range(0, 2) == 0);
        bus16.s_tdata[i*DW +: DW] = {$urandom, $urandom};
      end
      bus16.m_tready = ($urandom_range(0, 3) != 0);
      cycle16();
    end
    idle16();
    for (int c = 0; c < 4; c++) cycle16();
    chk("rand_beats_in_eq_out", 64'(beats_out), 64'(beats_in));
    chk("rand_drained", 64'(bus16.m_tvalid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
